// File: rtl/result_memory_writer.sv
// Buffers 4-filter result beats in a small FIFO and serialises them onto the
// single-port vector memory, one word per cycle, into the aligned result region.
module result_memory_writer #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [8:0] BASE_ADDR  = 9'h100
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic        r_element_ready,
    input  logic [15:0] r0_element,
    input  logic [15:0] r1_element,
    input  logic [15:0] r2_element,
    input  logic [15:0] r3_element,
    output logic        in_ready,
    output logic [8:0]  vector_memory_address,
    output logic [15:0] vector_write_element,
    output logic        memory_enable,
    output logic        memory_write,
    output logic [3:0]  element_index,
    output logic        busy,
    output logic        last_element,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full, empty, push, pop, issue;
    logic [63:0]   head_word;
    logic [15:0]   head_elem;

    state_t        state_reg, state_next;
    logic [1:0]    phase_reg;
    logic [3:0]    elem_reg;
    logic [8:0]    addr_reg;
    logic [15:0]   data_reg;
    logic          mem_en_reg, last_reg, overflow_reg;

    assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign in_ready = ~full;
    assign push     = r_element_ready && !full;

    // Storage carries no reset: clearing the pointers is enough to discard it.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {r3_element, r2_element, r1_element, r0_element};
    end

    assign head_word = fifo_mem[rd_ptr_reg];

    always_comb begin
        head_elem = head_word[15:0];
        case (phase_reg)
            2'd1:    head_elem = head_word[31:16];
            2'd2:    head_elem = head_word[47:32];
            2'd3:    head_elem = head_word[63:48];
            default: head_elem = head_word[15:0];
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Drain FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (issue) state_next = DRAIN;
            DRAIN: if (pop && count_reg == (AW+1)'(1) && !push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM: outputs. Phase 0 issues straight from IDLE to save a cycle.
    always_comb begin
        issue = en && !empty;
        pop   = issue && (phase_reg == 2'd3);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            phase_reg    <= 2'd0;
            elem_reg     <= 4'd0;
            addr_reg     <= 9'd0;
            data_reg     <= 16'd0;
            mem_en_reg   <= 1'b0;
            last_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            mem_en_reg   <= issue;
            last_reg     <= pop && (elem_reg == 4'd15);
            overflow_reg <= overflow_reg | (r_element_ready && full);
            if (issue) begin
                phase_reg <= phase_reg + 2'd1;
                addr_reg  <= BASE_ADDR + {3'b000, phase_reg, elem_reg};
                data_reg  <= head_elem;
            end
            if (pop)
                elem_reg <= elem_reg + 4'd1;
        end
    end

    assign vector_memory_address = addr_reg;
    assign vector_write_element  = data_reg;
    assign memory_enable         = mem_en_reg;
    assign memory_write          = mem_en_reg;
    assign element_index         = elem_reg;
    assign last_element          = last_reg;
    assign overflow              = overflow_reg;
    assign busy                  = !empty || (state_reg == DRAIN);

endmodule

// File: tb/tb_result_memory_writer.sv
// Bench for result_memory_writer: scoreboard of expected memory writes built
// from accepted beats, plus table-driven single beats and corner sequences.
module tb_result_memory_writer;

    localparam logic [8:0] BASE = 9'h100;

    logic        clock = 1'b0;
    logic        clear;
    logic        en;
    logic        r_element_ready;
    logic [15:0] r0_element, r1_element, r2_element, r3_element;
    logic        in_ready;
    logic [8:0]  vector_memory_address;
    logic [15:0] vector_write_element;
    logic        memory_enable, memory_write;
    logic [3:0]  element_index;
    logic        busy, last_element, overflow;

    result_memory_writer #(.FIFO_DEPTH(2), .BASE_ADDR(BASE)) dut (
        .clock(clock), .clear(clear), .en(en), .r_element_ready(r_element_ready),
        .r0_element(r0_element), .r1_element(r1_element),
        .r2_element(r2_element), .r3_element(r3_element),
        .in_ready(in_ready), .vector_memory_address(vector_memory_address),
        .vector_write_element(vector_write_element), .memory_enable(memory_enable),
        .memory_write(memory_write), .element_index(element_index), .busy(busy),
        .last_element(last_element), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    typedef struct packed {
        logic [15:0] d0, d1, d2, d3;
        logic [3:0]  idx;
    } vec_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  wr_log[$];
    int  tests = 0, fails = 0;
    int  exp_e = 0, pcyc = 0, last_acc = 0;
    int  wr_count = 0, last_count = 0;

    always @(posedge clock) pcyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every registered write must match the head of the scoreboard.
    always @(negedge clock) begin
        if (clear === 1'b0) begin
            if (memory_enable) begin
                wr_count++;
                wr_log.push_back(pcyc);
                if (last_element) last_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                             vector_memory_address, vector_write_element);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", vector_memory_address, mon_e.addr);
                    check("wr_data", vector_write_element, mon_e.data);
                    check("wr_last", last_element, mon_e.last);
                    check("wr_strobe", memory_write, 1);
                    $display("[TB] write addr=%03h data=%04h last=%0b", vector_memory_address,
                             vector_write_element, last_element);
                end
            end else begin
                check("idle_write", memory_write, 0);
                check("idle_last", last_element, 0);
            end
        end
    end

    // Called at a negedge; offers the beat until accepted, returns at a negedge.
    task automatic send_beat(input logic [15:0] d0, d1, d2, d3);
        logic [15:0] d[4];
        bit done = 0;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        r_element_ready = 1'b1;
        r0_element = d0; r1_element = d1; r2_element = d2; r3_element = d3;
        for (int c = 0; c < 64 && !done; c++) begin
            if (in_ready) begin
                done = 1;
                last_acc = pcyc + 1;
                for (int f = 0; f < 4; f++)
                    exp_q.push_back('{BASE + 9'(16 * f + exp_e), d[f], (f == 3 && exp_e == 15)});
                exp_e = (exp_e + 1) % 16;
            end
            @(negedge clock);
        end
        r_element_ready = 1'b0;
        check("beat_accepted", 32'(done), 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++)
            @(negedge clock);
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        exp_q.delete();
        exp_e = 0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_en"}, memory_enable, 0);
        check({tag, "_mem_wr"}, memory_write, 0);
        check({tag, "_addr"}, vector_memory_address, 0);
        check({tag, "_data"}, vector_write_element, 0);
        check({tag, "_last"}, last_element, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_index"}, element_index, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   acc[16];
        int   w0, e0;
        bit   found;

        vt[0] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 4'd1};
        vt[1] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 4'd2};
        vt[2] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 4'd3};
        vt[3] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'd4};
        vt[4] = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A, 4'd5};
        vt[5] = '{16'hC0DE, 16'hBEEF, 16'hCAFE, 16'hF00D, 4'd6};

        clear = 1'b1; en = 1'b0; r_element_ready = 1'b0;
        r0_element = '0; r1_element = '0; r2_element = '0; r3_element = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        clear = 1'b0;

        // Table-driven single beats with latency and index checks
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_log.delete();
            send_beat(vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3);
            drain();
            check("beat_writes", wr_log.size(), 4);
            for (int k = 0; k < 4 && k < wr_log.size(); k++)
                check("beat_latency", wr_log[k], last_acc + 1 + k);
            check("beat_index", element_index, vt[i].idx);
        end

        // 16 back-to-back beats throttled to 1 per 4 cycles
        do_clear();
        w0 = wr_count;
        last_count = 0;
        for (int e = 0; e < 16; e++) begin
            send_beat({8'd0, 8'(e)}, {8'd1, 8'(e)}, {8'd2, 8'(e)}, {8'd3, 8'(e)});
            acc[e] = last_acc;
        end
        drain();
        check("burst_second_accept", acc[1] - acc[0], 1);
        for (int e = 2; e < 16; e++)
            check("burst_accept_spacing", acc[e] - acc[e-1], 4);
        check("burst_writes", wr_count - w0, 64);
        check("burst_last_pulses", last_count, 1);
        check("burst_index_wrap", element_index, 0);

        // en held low for 3 cycles after the phase-1 write
        e0 = exp_e;
        send_beat(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (memory_enable && vector_memory_address == BASE + 9'(16 + e0)) found = 1;
            else @(negedge clock);
        end
        check("gap_sync", 32'(found), 1);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("gap_no_write", memory_enable, 0);
        end
        en = 1'b1;
        drain();
        check("gap_index", element_index, 4'(e0 + 1));

        // Full FIFO, third beat dropped, overflow sticky
        do_clear();
        en = 1'b0;
        send_beat(16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03);
        send_beat(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03);
        check("full_in_ready", in_ready, 0);
        r_element_ready = 1'b1;
        r0_element = 16'hDEAD; r1_element = 16'hDEAD; r2_element = 16'hDEAD; r3_element = 16'hDEAD;
        @(negedge clock);
        r_element_ready = 1'b0;
        check("overflow_set", overflow, 1);
        $display("[TB] dropped beat offered while full, overflow=%0b", overflow);
        w0 = wr_count;
        en = 1'b1;
        drain();
        check("overflow_writes", wr_count - w0, 8);
        check("overflow_sticky", overflow, 1);

        // Refill around a pop on a full FIFO; order preserved over 4 beats
        do_clear();
        check("clear_overflow", overflow, 0);
        en = 1'b0;
        send_beat(16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03);
        send_beat(16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03);
        en = 1'b1;
        send_beat(16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
        check("refill_full", in_ready, 0);
        send_beat(16'h1000, 16'h1001, 16'h1002, 16'h1003);
        drain();
        check("refill_index", element_index, 4);

        // Asynchronous clear in the middle of phase 2
        do_clear();
        send_beat(16'h2000, 16'h2001, 16'h2002, 16'h2003);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (memory_enable && vector_memory_address == BASE + 9'h010) found = 1;
            else @(negedge clock);
        end
        check("clear_sync", 32'(found), 1);
        #2;
        clear = 1'b1;
        exp_q.delete();
        exp_e = 0;
        #1;
        check_reset_outputs("async_clear");
        @(negedge clock);
        clear = 1'b0;
        send_beat(16'h3000, 16'h3001, 16'h3002, 16'h3003);
        drain();
        check("after_clear_index", element_index, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
